// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared types and helpers for the FIFO control blocks.
//   arb_state_t   : write-arbiter FSM state encoding {IDLE, BURST}
//   DEFAULT_DBITS : default FIFO data width per beat
//   clog2()       : index/counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int DEFAULT_DBITS = 8;

   // Width needed to hold the values 0..value-1. A width of at least one bit
   // is returned so single-entry cases still produce a legal vector.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Finds the first set bit of req,
// searching upward from index start and wrapping past NReq-1 back to 0.
// Ports:
//   req   in  NReq  request vector
//   start in  IdW   index that has highest priority this cycle
//   found out 1     at least one request bit is set
//   idx   out IdW   index of the winning request (0 when found is low)
// -----------------------------------------------------------------------------
module rr_pick
   import fifo_ctrl_pkg::*;
#(
   parameter int NReq = 4,
   parameter int IdW  = clog2(NReq)
) (
   input  logic [NReq-1:0] req,
   input  logic [IdW-1:0]  start,
   output logic            found,
   output logic [IdW-1:0]  idx
);

   int cand;

   // Walk the candidates in priority order; the found guard makes the
   // nearest set bit to start win.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the block leaves a value held and no latch is inferred.
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = 0; k < NReq; k++) begin
         cand = (int'(start) + k) % NReq;
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = IdW'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Shares the single FIFO write port between NReq producers. Round-robin
// arbitration; a grantee keeps the port for up to MaxBurst consecutive beats
// before priority rotates to the next index. The write path is combinational
// so a beat moves from a producer into the FIFO in the same cycle.
// Ports:
//   clk             in  1           system clock, rising edge
//   areset          in  1           asynchronous active-high reset
//   req_valid       in  NReq        per-requester beat valid
//   req_data        in  NReq*DBits  requester i at [i*DBits +: DBits]
//   req_ready       out NReq        per-requester accept (grantee only)
//   Full            in  1           FIFO full flag
//   Write_Enable    out 1           FIFO write strobe
//   Input_Data_bits out DBits       FIFO write data
//   grant_id        out clog2(NReq) current grantee, meaningful with Write_Enable
//   busy            out 1           high while a burst is locked
// -----------------------------------------------------------------------------
module fifo_write_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int DBits    = DEFAULT_DBITS,
   parameter int NReq     = 4,
   parameter int MaxBurst = 4
) (
   input  logic                    clk,
   input  logic                    areset,
   input  logic [NReq-1:0]         req_valid,
   input  logic [NReq*DBits-1:0]   req_data,
   output logic [NReq-1:0]         req_ready,
   input  logic                    Full,
   output logic                    Write_Enable,
   output logic [DBits-1:0]        Input_Data_bits,
   output logic [clog2(NReq)-1:0]  grant_id,
   output logic                    busy
);

   localparam int IdW  = clog2(NReq);
   localparam int CntW = clog2(MaxBurst + 1);
   localparam logic [IdW-1:0]  LAST_ID   = IdW'(NReq - 1);
   localparam logic [CntW-1:0] BURST_END = CntW'(MaxBurst);

   arb_state_t      state;
   logic [IdW-1:0]  rr_ptr;
   logic [IdW-1:0]  owner;
   logic [CntW-1:0] beat_cnt;

   logic            pick_found;
   logic [IdW-1:0]  pick_idx;
   logic            have_gnt;
   logic [IdW-1:0]  gnt;
   logic            xfer;
   logic [DBits-1:0] slot [NReq];

   // Index after id, wrapping at NReq (NReq need not be a power of two).
   function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
      return (id == LAST_ID) ? '0 : id + 1'b1;
   endfunction

   for (genvar i = 0; i < NReq; i++) begin : g_slot
      assign slot[i] = req_data[i*DBits +: DBits];
   end

   rr_pick #(
      .NReq (NReq),
      .IdW  (IdW)
   ) u_pick (
      .req   (req_valid),
      .start (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grantee selection and the combinational write path. In BURST the owner
   // stays the grantee even with valid low, so no other requester can slip
   // in on the release cycle. Every output is forced low during reset.
   always_comb begin
      have_gnt        = 1'b0;
      gnt             = '0;
      xfer            = 1'b0;
      req_ready       = '0;
      Write_Enable    = 1'b0;
      Input_Data_bits = '0;
      grant_id        = '0;
      busy            = 1'b0;

      if (state == IDLE) begin
         have_gnt = pick_found;
         gnt      = pick_idx;
      end else begin
         have_gnt = 1'b1;
         gnt      = owner;
      end

      if (!areset) begin
         xfer         = have_gnt && req_valid[gnt] && !Full;
         Write_Enable = xfer;
         busy         = (state == BURST);
         grant_id     = gnt;
         if (have_gnt) begin
            Input_Data_bits = slot[gnt];
         end
         if (xfer) begin
            req_ready[gnt] = 1'b1;
         end
      end
   end

   // Arbitration state. A Full stall changes nothing; only a completed
   // transfer or the owner dropping valid moves the FSM.
   always_ff @(posedge clk or posedge areset) begin
      // NOTE: registered state is assigned with <= so every flop samples the
      // pre-edge values and the update order inside the block is irrelevant.
      if (areset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  if (MaxBurst == 1) begin
                     rr_ptr <= next_id(gnt);
                  end else begin
                     state    <= BURST;
                     owner    <= gnt;
                     beat_cnt <= CntW'(1);
                  end
               end
            end
            BURST: begin
               if (!req_valid[owner]) begin
                  // Owner ran dry: give up the port without a transfer.
                  state  <= IDLE;
                  rr_ptr <= next_id(owner);
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt + 1'b1 == BURST_END) begin
                     state  <= IDLE;
                     rr_ptr <= next_id(owner);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (DBits=8, NReq=4, MaxBurst=4).
// Each scenario pushes its hand-computed beat sequence {grant_id, data, busy}
// into a scoreboard queue; an independent monitor pops and compares on every
// cycle where the DUT asserts Write_Enable. Producers are small per-requester
// counters that advance only on completed handshakes.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   localparam int NREQ = 4;
   localparam int DB   = 8;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      logic       busy;
   } exp_t;

   logic              clk = 1'b0;
   logic              areset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*DB-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              Full;
   logic              Write_Enable;
   logic [DB-1:0]     Input_Data_bits;
   logic [1:0]        grant_id;
   logic              busy;

   int                n_tests = 0;
   int                n_fail  = 0;
   exp_t              exp_q[$];
   exp_t              mon_e;

   int                remaining [NREQ];
   logic [7:0]        nxt       [NREQ];
   logic [NREQ-1:0]   xfer_q;

   fifo_write_arbiter #(
      .DBits    (DB),
      .NReq     (NREQ),
      .MaxBurst (4)
   ) dut (
      .clk             (clk),
      .areset          (areset),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .Full            (Full),
      .Write_Enable    (Write_Enable),
      .Input_Data_bits (Input_Data_bits),
      .grant_id        (grant_id),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Handshakes completed at each edge, seen with pre-edge values.
   always @(posedge clk) xfer_q <= req_valid & req_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic expect_beat(input logic [1:0] id, input logic [7:0] data, input logic b);
      exp_t e;
      e.id = id; e.data = data; e.busy = b;
      exp_q.push_back(e);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = (remaining[i] > 0);
         req_data[i*DB +: DB] = nxt[i];
      end
   endtask

   task automatic load(input int i, input logic [7:0] base, input int cnt);
      remaining[i] = cnt;
      nxt[i]       = base;
      drive();
   endtask

   // One clock: producers that handshook move to their next beat.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (xfer_q[i]) begin
            remaining[i] = remaining[i] - 1;
            nxt[i]       = nxt[i] + 8'd1;
         end
      end
      drive();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      step();
      step();
      areset = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: compares every presented write against the scoreboard.
   always @(negedge clk) begin
      if (!areset) begin
         if (Full) check("no_write_while_full", Write_Enable, 1'b0);
         if (Write_Enable) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got id %0d data %0h, wanted no write (t=%0t)",
                        grant_id, Input_Data_bits, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_grant_id", grant_id, mon_e.id);
               check("beat_data", Input_Data_bits, mon_e.data);
               check("beat_busy", busy, mon_e.busy);
               check("beat_ready_onehot", req_ready, 4'b0001 << mon_e.id);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "watchdog");
   end

   initial begin
      areset    = 1'b1;
      Full      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         remaining[i] = 0;
         nxt[i]       = 8'h00;
      end

      // Reset and idle: all producers valid while reset is held.
      for (int i = 0; i < NREQ; i++) load(i, 8'h11 * (i + 1), 1);
      @(negedge clk);
      check("rst_write_enable", Write_Enable, 1'b0);
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_data", Input_Data_bits, 8'h00);
      check("rst_grant_id", grant_id, 2'd0);
      check("rst_busy", busy, 1'b0);
      step();
      step();
      for (int i = 0; i < NREQ; i++) load(i, 8'h00, 0);
      areset = 1'b0;
      step();
      @(negedge clk);
      check("idle_write_enable", Write_Enable, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_data", Input_Data_bits, 8'h00);
      check("idle_req_ready", req_ready, 4'b0000);

      // Single requester: burst of 4, release, then regrant for the rest.
      for (int k = 0; k < 6; k++) expect_beat(2'd1, 8'hA0 + 8'(k), (k != 0 && k != 4));
      load(1, 8'hA0, 6);
      wait_drain(40);
      step();
      step();

      // Round robin with everyone valid and FIFO never full.
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int id = 0; id < NREQ; id++)
            for (int k = 0; k < 4; k++)
               expect_beat(2'(id), 8'h10 * 8'(id + 1) + 8'(r * 4 + k), (k != 0));
      for (int i = 0; i < NREQ; i++) load(i, 8'h10 * 8'(i + 1), 8);
      wait_drain(80);
      step();

      // Full for 3 cycles on req2's 2nd beat; req3 waits to catch a short burst.
      do_reset();
      expect_beat(2'd2, 8'hC0, 1'b0);
      expect_beat(2'd2, 8'hC1, 1'b1);
      expect_beat(2'd2, 8'hC2, 1'b1);
      expect_beat(2'd2, 8'hC3, 1'b1);
      expect_beat(2'd3, 8'hD0, 1'b0);
      expect_beat(2'd2, 8'hC4, 1'b0);
      load(2, 8'hC0, 5);
      load(3, 8'hD0, 1);
      step();
      Full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("full_write_enable", Write_Enable, 1'b0);
         check("full_req_ready", req_ready, 4'b0000);
         check("full_busy_held", busy, 1'b1);
         step();
      end
      Full = 1'b0;
      wait_drain(40);
      step();
      step();

      // Early release: req3 runs dry after 2 beats; req0 then req1 follow.
      do_reset();
      expect_beat(2'd3, 8'hE0, 1'b0);
      expect_beat(2'd3, 8'hE1, 1'b1);
      expect_beat(2'd0, 8'hF0, 1'b0);
      expect_beat(2'd0, 8'hF1, 1'b1);
      expect_beat(2'd1, 8'h50, 1'b0);
      load(3, 8'hE0, 2);
      step();
      load(0, 8'hF0, 2);
      load(1, 8'h50, 1);
      step();
      @(negedge clk);
      check("release_no_write", Write_Enable, 1'b0);
      check("release_cycle_busy", busy, 1'b1);
      wait_drain(40);
      step();
      step();

      // Reset mid-burst, with rr_ptr left at 2 by the previous scenario.
      expect_beat(2'd1, 8'h80, 1'b0);
      expect_beat(2'd1, 8'h81, 1'b1);
      load(1, 8'h80, 4);
      step();
      step();
      check("pre_reset_write_enable", Write_Enable, 1'b1);
      areset = 1'b1;
      #1;
      check("reset_drops_write_enable", Write_Enable, 1'b0);
      check("reset_drops_busy", busy, 1'b0);
      check("reset_drops_ready", req_ready, 4'b0000);
      expect_beat(2'd1, 8'h82, 1'b0);
      expect_beat(2'd1, 8'h83, 1'b1);
      expect_beat(2'd3, 8'h90, 1'b0);
      step();
      load(3, 8'h90, 1);
      areset = 1'b0;
      wait_drain(40);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
